program_mem_arbiter: RTL and testbench

Shares a single program-memory read channel among `NUM_CORES` compute cores, replacing the fixed pair of per-core program channels with one parametrised, round-robin-arbitrated port. It sits between the cores' fetchers and the program memory controller. It accepts one fetch at a time, forwards it to memory, and returns the instruction word to the granted core. Compile-time coalescing lets several cores that fetch the same PC share one memory access.

---
 rtl/gpu_pkg.sv | 19 +
 rtl/pma_rr_pick.sv | 42 ++++
 rtl/program_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_program_mem_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and helpers for the program-memory arbiter: the arbiter FSM
// state encoding and the core-index width function.
package gpu_pkg;

  // Arbiter FSM states. One transaction walks IDLE->REQUEST->RESPOND->RELEASE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } pma_state_t;

  // Width needed to hold a core index. A single-core build still keeps a
  // 1-bit index so that no zero-width vectors are ever declared.
  function automatic int core_idx_bits(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/pma_rr_pick.sv
// Rotating-priority picker. Returns the first asserted request at or above
// rr_ptr, wrapping past the top index back to 0. Purely combinational.
module pma_rr_pick
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int IDX_BITS  = core_idx_bits(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_BITS-1:0]  rr_ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_BITS-1:0]  winner,
  output logic                 any_req
);

  // Two-pass search: first the upper segment [rr_ptr, NUM_CORES-1], then the
  // wrapped segment [0, rr_ptr-1]. The first hit in that order wins, which is
  // exactly an upward modulo search starting at rr_ptr, and every index used
  // is a loop constant so no variable bit-select is needed.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant   = '0;
    winner  = '0;
    any_req = |req;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!found && req[j] && (j >= int'(rr_ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        winner   = IDX_BITS'(j);
      end
    end
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        winner   = IDX_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter: shares one program-memory read channel among NUM_CORES
// instruction fetchers using round-robin arbitration. One fetch is in flight at
// a time: the winner's address is latched, sent to memory, and the returned word
// is presented to the served core(s) with a one-cycle ready pulse. The block then
// waits for the served cores to drop valid before arbitrating again, so a valid
// left high after its ready can never be granted twice for the same fetch.
//
// Optional build macro:
//   PMA_BROADCAST_EN - coalesce fetches: every core whose valid is high and whose
//                      address matches the winner's at grant time is served by
//                      the same memory access. Without it only the winner is
//                      served and the address comparators are not built.
//
// All outputs are registered or decoded from registered state only.
module program_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_CORES             = 2,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_CORES-1:0]                                core_read_valid,
  input  logic [NUM_CORES-1:0][PROGRAM_MEM_ADDR_BITS-1:0]     core_read_address,
  output logic [NUM_CORES-1:0]                                core_read_ready,
  output logic [NUM_CORES-1:0][PROGRAM_MEM_DATA_BITS-1:0]     core_read_data,
  output logic                                                mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                                mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0]                    mem_read_data,
  output logic                                                busy
);

  localparam int IDX_BITS = core_idx_bits(NUM_CORES);

  // FSM state
  pma_state_t state;
  pma_state_t state_next;

  // Arbitration bookkeeping
  logic [IDX_BITS-1:0]              rr_ptr;
  logic [IDX_BITS-1:0]              rr_ptr_next;
  logic [IDX_BITS-1:0]              winner_q;
  logic [NUM_CORES-1:0]             served_mask;

  // Latched transaction payload
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q;

  // Picker results for the current cycle
  logic [NUM_CORES-1:0]             pick_grant;
  logic [IDX_BITS-1:0]              pick_winner;
  logic                             pick_any;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pick_addr;
  logic [NUM_CORES-1:0]             grant_mask;

  pma_rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_BITS  (IDX_BITS)
  ) u_pick (
    .req     (core_read_valid),
    .rr_ptr  (rr_ptr),
    .grant   (pick_grant),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // Select the winner's address with the one-hot grant (OR of masked lanes).
  always_comb begin
    pick_addr = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (pick_grant[j]) begin
        pick_addr = pick_addr | core_read_address[j];
      end
    end
  end

`ifdef PMA_BROADCAST_EN
  // Coalesce every requesting core that fetches the winner's PC into one access.
  always_comb begin
    grant_mask = pick_grant;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (core_read_valid[j] && (core_read_address[j] == pick_addr)) begin
        grant_mask[j] = 1'b1;
      end
    end
  end
`else
  // Without coalescing only the round-robin winner is served.
  always_comb begin
    grant_mask = pick_grant;
  end
`endif

  // Advance the round-robin pointer past the winner, wrapping the top core to 0.
  always_comb begin
    if (winner_q == IDX_BITS'(NUM_CORES - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = winner_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (mem_read_ready) begin
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        // Hold here until every served core has let go of its request.
        if ((core_read_valid & served_mask) == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Transaction registers: grant capture, memory word capture, pointer update.
  // A reset mid-transaction simply drops everything; no ready is ever pulsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      winner_q    <= '0;
      served_mask <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            winner_q    <= pick_winner;
            addr_q      <= pick_addr;
            served_mask <= grant_mask;
          end
        end
        REQUEST: begin
          // Memory responses are only accepted while a request is outstanding.
          if (mem_read_ready) begin
            data_q <= mem_read_data;
          end
        end
        RESPOND: begin
          rr_ptr <= rr_ptr_next;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state and latched payload.
  always_comb begin
    mem_read_valid   = (state == REQUEST);
    mem_read_address = addr_q;
    core_read_ready  = (state == RESPOND) ? served_mask : '0;
    busy             = (state != IDLE);
    for (int j = 0; j < NUM_CORES; j++) begin
      core_read_data[j] = data_q;
    end
  end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Self-checking bench for program_mem_arbiter with four cores. A small memory
// model answers requests after a programmable latency; expected core responses
// are queued as stimulus is applied and checked whenever ready pulses.
module tb_program_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NC-1:0]         core_read_valid;
  logic [NC-1:0][AW-1:0] core_read_address;
  logic [NC-1:0]         core_read_ready;
  logic [NC-1:0][DW-1:0] core_read_data;
  logic                  mem_read_valid;
  logic [AW-1:0]         mem_read_address;
  logic                  mem_read_ready;
  logic [DW-1:0]         mem_read_data;
  logic                  busy;

  typedef struct {
    logic [NC-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] mem_log[$];
  logic [DW-1:0] mem[256];
  int            lat = 1;
  bit            stray_req = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  program_mem_arbiter #(
    .NUM_CORES             (NC),
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .core_read_valid   (core_read_valid),
    .core_read_address (core_read_address),
    .core_read_ready   (core_read_ready),
    .core_read_data    (core_read_data),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .busy              (busy)
  );

  // Memory model: counts cycles of mem_read_valid, answers after lat cycles.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_read_ready = 1'b0;
        cnt = 0;
      end else if (mem_read_ready) begin
        mem_read_ready = 1'b0;
        cnt = 0;
      end else if (stray_req) begin
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        stray_req = 1'b0;
      end else if (mem_read_valid) begin
        cnt++;
        if (cnt >= lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[mem_read_address];
          mem_log.push_back(mem_read_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every ready pulse must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && core_read_ready !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ready: got ready=%b, required no ready", core_read_ready);
        end else begin
          e = sb.pop_front();
          if (core_read_ready !== e.mask) begin
            errors++;
            $display("FAIL sb_ready_mask: got %b, required %b", core_read_ready, e.mask);
          end
          for (int i = 0; i < NC; i++) begin
            if (e.mask[i]) begin
              checks++;
              if (core_read_data[i] !== e.data) begin
                errors++;
                $display("FAIL sb_data_lane%0d: got %h, required %h", i, core_read_data[i], e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    core_read_valid = '0;
    core_read_address = '0;
    stray_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_log.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drop each core's valid as soon as its ready is seen; ok once all served.
  task automatic serve(input logic [NC-1:0] want, output bit ok);
    logic [NC-1:0] pending;
    pending = want;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      pending = pending & ~core_read_ready;
      core_read_valid = core_read_valid & ~core_read_ready;
      if (pending == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_read_valid = 4'b1111;
    core_read_address = {8'h04, 8'h03, 8'h02, 8'h01};
    repeat (2) @(negedge clk);
    checks++;
    if (mem_read_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got mem_valid=%b busy=%b, required 0 0", mem_read_valid, busy);
    end
    checks++;
    if (core_read_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 0000", core_read_ready);
    end
    checks++;
    if (core_read_data !== '0 || mem_read_address !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h addr=%h, required 0 0", core_read_data, mem_read_address);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr);
    end
    reset = 1'b0;
    core_read_valid = '0;
    @(negedge clk);
    mem_log.delete();
  endtask

  task automatic test_single();
    int  cyc;
    bit  ok;
    do_reset();
    lat = 3;
    sb.push_back('{mask: 4'b0010, data: 16'hABCD});
    core_read_address[1] = 8'h12;
    core_read_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h12) begin
      errors++;
      $display("FAIL single_mem_req: got valid=%b addr=%h, required 1 12", mem_read_valid, mem_read_address);
    end
    cyc = 1;
    while (core_read_ready === '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != lat + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required %0d", cyc, lat + 1);
    end
    checks++;
    if (core_read_ready !== 4'b0010 || core_read_data[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL single_resp: got ready=%b data=%h, required 0010 abcd", core_read_ready, core_read_data[1]);
    end
    core_read_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (core_read_ready !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse_width: got ready=%b busy=%b, required 0000 1", core_read_ready, busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || dut.rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL single_rr_ptr: got idle=%0d rr_ptr=%0d, required 1 2", ok, dut.rr_ptr);
    end
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    int got[$];
    int rel[NC];
    bit ok;
    do_reset();
    lat = 1;
    foreach (order[k]) sb.push_back('{mask: 4'b0001 << order[k], data: mem[8'h20 + order[k]]});
    for (int i = 0; i < NC; i++) begin
      core_read_address[i] = 8'(8'h20 + i);
      rel[i] = 0;
    end
    core_read_valid = 4'b1111;
    for (int c = 0; c < 300 && got.size() < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (rel[i] > 0) begin
          rel[i]--;
          if (rel[i] == 0) core_read_valid[i] = 1'b1;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (core_read_ready[i] === 1'b1) begin
          got.push_back(i);
          core_read_valid[i] = 1'b0;
          rel[i] = 3;
        end
      end
    end
    core_read_valid = '0;
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL fair_count: got %0d grants, required 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] != order[k]) begin
          errors++;
          $display("FAIL fair_order%0d: got core %0d, required core %0d", k, got[k], order[k]);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || mem_log.size() != 5 || mem_log[4] !== 8'h20 || mem_log[3] !== 8'h23) begin
      errors++;
      $display("FAIL fair_mem_reads: got idle=%0d reads=%0d, required 1 5 ending 23,20", ok, mem_log.size());
    end
  endtask

  task automatic test_release_guard();
    int  cyc;
    bit  ok;
    do_reset();
    lat = 1;
    sb.push_back('{mask: 4'b0001, data: mem[8'h30]});
    core_read_address[0] = 8'h30;
    core_read_valid[0] = 1'b1;
    cyc = 0;
    while (core_read_ready[0] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (core_read_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL guard_ready_timeout: got ready=%b, required 0001", core_read_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (mem_read_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL guard_hold%0d: got mem_valid=%b busy=%b, required 0 1", k, mem_read_valid, busy);
      end
    end
    core_read_valid[0] = 1'b0;
    wait_idle(ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || mem_log.size() != 1 || mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL guard_reads: got idle=%0d reads=%0d, required 1 1", ok, mem_log.size());
    end
  endtask

  task automatic test_broadcast();
    logic [AW-1:0] exp_log[$];
    bit ok;
    do_reset();
    lat = 2;
`ifdef PMA_BROADCAST_EN
    sb.push_back('{mask: 4'b0101, data: mem[8'h40]});
    sb.push_back('{mask: 4'b0010, data: mem[8'h41]});
    exp_log = '{8'h40, 8'h41};
`else
    sb.push_back('{mask: 4'b0001, data: mem[8'h40]});
    sb.push_back('{mask: 4'b0010, data: mem[8'h41]});
    sb.push_back('{mask: 4'b0100, data: mem[8'h40]});
    exp_log = '{8'h40, 8'h41, 8'h40};
`endif
    core_read_address = {8'h00, 8'h40, 8'h41, 8'h40};
    core_read_valid = 4'b0111;
    serve(4'b0111, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bcast_timeout: got pending valids=%b, required all served", core_read_valid);
    end
    wait_idle(ok);
    checks++;
    if (mem_log.size() != exp_log.size()) begin
      errors++;
      $display("FAIL bcast_read_count: got %0d, required %0d", mem_log.size(), exp_log.size());
    end else begin
      foreach (exp_log[k]) begin
        checks++;
        if (mem_log[k] !== exp_log[k]) begin
          errors++;
          $display("FAIL bcast_addr%0d: got %h, required %h", k, mem_log[k], exp_log[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    do_reset();
    lat = 1;
    sb.push_back('{mask: 4'b0010, data: mem[8'h12]});
    core_read_address[1] = 8'h12;
    core_read_valid[1] = 1'b1;
    serve(4'b0010, ok);
    wait_idle(ok);
    mem_log.delete();
    lat = 20;
    core_read_address[3] = 8'h55;
    core_read_valid[3] = 1'b1;
    cyc = 0;
    while (mem_read_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mem_read_valid !== 1'b1 || dut.rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL rmid_setup: got mem_valid=%b rr_ptr=%0d, required 1 2", mem_read_valid, dut.rr_ptr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read_valid !== 1'b0 || busy !== 1'b0 || core_read_ready !== '0) begin
      errors++;
      $display("FAIL rmid_outputs: got mem_valid=%b busy=%b ready=%b, required 0 0 0000", mem_read_valid, busy, core_read_ready);
    end
    checks++;
    if (mem_read_address !== '0 || core_read_data !== '0 || dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rmid_state: got addr=%h data=%h rr_ptr=%0d, required 0 0 0", mem_read_address, core_read_data, dut.rr_ptr);
    end
    reset = 1'b0;
    core_read_valid = '0;
    repeat (25) @(negedge clk);
    checks++;
    if (mem_log.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abandon: got reads=%0d busy=%b, required 0 0", mem_log.size(), busy);
    end
  endtask

  task automatic test_ignored();
    int cyc;
    bit ok;
    do_reset();
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_read_valid !== 1'b0 || core_read_ready !== '0 || core_read_data[0] !== '0) begin
      errors++;
      $display("FAIL stray_ready: got busy=%b mem_valid=%b ready=%b data=%h, required 0 0 0000 0",
               busy, mem_read_valid, core_read_ready, core_read_data[0]);
    end
    lat = 4;
    sb.push_back('{mask: 4'b0001, data: mem[8'h60]});
    core_read_address[0] = 8'h60;
    core_read_address[1] = 8'h61;
    core_read_valid[0] = 1'b1;
    cyc = 0;
    while (mem_read_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    core_read_valid[1] = 1'b1;
    @(negedge clk);
    core_read_valid[1] = 1'b0;
    serve(4'b0001, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL late_timeout: got pending valids=%b, required core0 served", core_read_valid);
    end
    wait_idle(ok);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_log.size() != 1 || dut.rr_ptr !== 2'd1) begin
      errors++;
      $display("FAIL late_pulse: got busy=%b reads=%0d rr_ptr=%0d, required 0 1 1", busy, mem_log.size(), dut.rr_ptr);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    core_read_valid = '0;
    core_read_address = '0;
    for (int a = 0; a < 256; a++) mem[a] = {8'(a), 8'(a) ^ 8'h5A};
    mem[8'h12] = 16'hABCD;
    test_reset();
    test_single();
    test_fairness();
    test_release_guard();
    test_broadcast();
    test_reset_mid();
    test_ignored();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d undelivered responses, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
